// File: rtl/mux_arb_rr_if.sv
// mux_arb_rr_if: channel-side and output-side handshake bundle for mux_arb_rr
interface mux_arb_rr_if #(
  parameter int WIDTH = 16,
  parameter int NCH = 16,
  parameter int SELW = $clog2(NCH) + 1
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_ready;
  logic mode;
  logic [SELW-1:0] fn_sel;
  logic [WIDTH-1:0] out_data;
  logic [SELW-1:0] out_ch;
  logic out_valid;
  logic out_ready;
  logic sel_err;
  modport master(
    output in_data, in_valid, mode, fn_sel, out_ready,
    input in_ready, out_data, out_ch, out_valid, sel_err
  );
  modport slave(
    input in_data, in_valid, mode, fn_sel, out_ready,
    output in_ready, out_data, out_ch, out_valid, sel_err
  );
endinterface

// File: rtl/mux_arb_rr.sv
// mux_arb_rr: fixed-select or round-robin N-channel mux into a single full-throughput output register
module mux_arb_rr #(
  parameter int WIDTH = 16,
  parameter int NCH = 16,
  parameter int SELW = $clog2(NCH) + 1
) (
  input logic clk,
  input logic rst_n,
  mux_arb_rr_if.slave bus
);
  localparam int PW = $clog2(NCH);
  logic [PW-1:0] ptr;
  logic [PW-1:0] rr_g;
  logic [PW-1:0] ch;
  logic rr_hit;
  logic load_en;
  logic fix_ok;
  logic grant_en;
  logic xfer;
  assign load_en = !bus.out_valid || bus.out_ready;
  assign fix_ok = bus.fn_sel < SELW'(NCH);
  always_comb begin
    rr_hit = 1'b0;
    rr_g = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (bus.in_valid[PW'((int'(ptr) + k) % NCH)]) begin
        rr_hit = 1'b1;
        rr_g = PW'((int'(ptr) + k) % NCH);
      end
  end
  assign ch = bus.mode ? rr_g : bus.fn_sel[PW-1:0];
  assign grant_en = rst_n && load_en && (bus.mode ? rr_hit : fix_ok);
  assign bus.in_ready = grant_en ? NCH'(1) << ch : '0;
  assign xfer = |(bus.in_ready & bus.in_valid);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_ch <= '0;
      bus.sel_err <= 1'b0;
      ptr <= '0;
    end else begin
      bus.sel_err <= !bus.mode && !fix_ok;
      if (xfer) begin
        bus.out_valid <= 1'b1;
        bus.out_data <= bus.in_data[ch*WIDTH +: WIDTH];
        bus.out_ch <= SELW'(ch);
        if (bus.mode) ptr <= rr_g == PW'(NCH - 1) ? '0 : rr_g + 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/mux_arb_rr.md
MUX_ARB_RR -- requirements
Module: mux_arb_rr

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  - WIDTH, 16, data bits per channel.
  - NCH, 16, number of input channels (>=2).
  - SELW, $clog2(NCH)+1, select width; the extra bit makes out-of-range selects representable.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  - clk, in, 1, sole clock; all state updates on its rising edge.
  - rst_n, in, 1, synchronous active-low reset.
  - in_data, in, NCH*WIDTH, packed channel data; channel i at [i*WIDTH +: WIDTH].
  - in_valid, in, NCH, per-channel valid.
  - in_ready, out, NCH, per-channel ready (combinational).
  - mode, in, 1, 0 = fixed select, 1 = round-robin.
  - fn_sel, in, SELW, channel index used when mode=0.
  - out_data, out, WIDTH, registered selected data.
  - out_ch, out, SELW, registered index of the source channel.
  - out_valid, out, 1, output register holds data.
  - out_ready, in, 1, downstream accept.
  - sel_err, out, 1, registered out-of-range select flag.

Function
REQ-003 load_en SHALL equal (!out_valid || out_ready); the output stage SHALL be a single register with full throughput (one transfer per cycle).
REQ-004 A transfer on channel c SHALL occur in a cycle where in_valid[c] && in_ready[c]; out_data, out_ch and out_valid=1 SHALL update at the next edge (latency 1).
REQ-005 At most one in_ready bit SHALL be high in any cycle; every in_ready bit SHALL be 0 when load_en=0.
REQ-006 In fixed mode (mode=0) with fn_sel<NCH, in_ready[fn_sel] SHALL equal load_en and all other in_ready bits SHALL be 0.
REQ-007 In fixed mode with fn_sel>=NCH, all in_ready bits SHALL be 0, no transfer SHALL occur, and sel_err SHALL be 1 in the following cycle.
REQ-008 sel_err SHALL be a registered copy of (mode==0 && fn_sel>=NCH), recomputed every cycle; it is not sticky.
REQ-009 In round-robin mode (mode=1), the grant SHALL be the first channel with in_valid set, searching ptr, ptr+1, ... NCH-1, 0, ... ptr-1.
REQ-010 After a round-robin transfer from channel g, ptr SHALL become (g+1) mod NCH, wrapping NCH-1 to 0.
REQ-011 ptr SHALL NOT change on cycles without a round-robin transfer, including all fixed-mode cycles; it is preserved across mode switches.
REQ-012 When no in_valid bit is set, no transfer SHALL occur. If out_ready=1, out_valid SHALL drop to 0 at the next edge.
REQ-013 While out_valid=1 and out_ready=0, out_data and out_ch SHALL hold stable.
REQ-014 A transfer SHALL complete in the same cycle as a downstream accept (out_valid && out_ready); out_valid SHALL remain 1.
REQ-015 mode and fn_sel SHALL be sampled combinationally each cycle; a change takes effect in that same cycle's selection. Data already registered is unaffected.
REQ-016 out_data SHALL be the selected WIDTH-bit slice with no extension or truncation.

Reset
REQ-017 With rst_n=0 at an edge, the following SHALL load: out_valid=0, out_data=0, out_ch=0, sel_err=0, ptr=0.
REQ-018 While rst_n=0, all in_ready bits SHALL be 0. Reset asserted mid-stream SHALL discard the held output word.
REQ-019 After rst_n rises, channel 0 SHALL have highest round-robin priority.

Verification
REQ-020 Fixed select: mode=0, ch3 data=0x1234 valid, fn_sel=3, out_ready=1 -> next cycle out_data=0x1234, out_ch=3, out_valid=1; other in_ready bits are 0.
REQ-021 Out-of-range select: mode=0, fn_sel=16, all in_valid set -> in_ready=0, sel_err=1 next cycle, out_valid falls to 0.
REQ-022 Round-robin fairness: mode=1, in_valid=0xFFFF held, out_ready=1 -> out_ch sequence 0,1,...,15,0; one output per cycle.
REQ-023 Wrap-around: ptr=15, in_valid=0x8001 -> grant order 15, 0, 15, 0.
REQ-024 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data and out_ch stable, in_ready=0; the pending channel transfers on the release cycle.
REQ-025 Reset mid-stream: rst_n=0 for one edge while out_valid=1 -> out_valid=0, out_data=0; the next round-robin grant starts from ch0.
